// File: rtl/address_generator_multi.sv
// Multi-channel BRAM address generator: per-channel wrapping word counters emitted as byte addresses,
// channel 0 drives the pass restart strobe. Define ADDRESS_GENERATOR_LATENCY_EN to delay restart/tvalid by two cycles.
module address_generator_multi #(
    parameter int N_CHANNELS = 2,
    parameter int WIDTH      = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [31:0]                       cfg,
    input  logic [N_CHANNELS*WIDTH-1:0]       period,
    output logic [N_CHANNELS*(WIDTH+2)-1:0]   addr,
    output logic                              restart,
    output logic                              tvalid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] count_r  [N_CHANNELS];
    logic [WIDTH-1:0] count_s  [N_CHANNELS];
    logic [WIDTH-1:0] shadow_r [N_CHANNELS];
    logic [WIDTH-1:0] shadow_s [N_CHANNELS];
    logic             cfg2_r;
    logic             sw_rise_s;
    logic             wrap0_s;
    logic             restart_r;
    logic             restart_s;
    logic             tvalid_r;
    logic             tvalid_s;
    logic             unused_cfg_s;

    assign sw_rise_s    = cfg[2] & ~cfg2_r;
    assign wrap0_s      = (count_r[0] == shadow_r[0]);
    assign unused_cfg_s = ^cfg[31:3];

    // Next-state, counter and shadow logic; cfg[0] low dominates, then software restart, then wraps.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        shadow_s  = shadow_r;
        restart_s = 1'b0;
        tvalid_s  = 1'b0;
        case (state_r)
            IDLE: begin
                for (int i = 0; i < N_CHANNELS; i++) begin
                    count_s[i] = {WIDTH{1'b0}};
                end
                if (cfg[0]) begin
                    state_s   = RUN;
                    restart_s = 1'b1;
                    tvalid_s  = 1'b1;
                    for (int i = 0; i < N_CHANNELS; i++) begin
                        shadow_s[i] = period[i*WIDTH +: WIDTH];
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!cfg[0]) begin
                    state_s = IDLE;
                    for (int i = 0; i < N_CHANNELS; i++) begin
                        count_s[i] = {WIDTH{1'b0}};
                    end
                end else if (sw_rise_s) begin
                    restart_s = 1'b1;
                    tvalid_s  = 1'b1;
                    for (int i = 0; i < N_CHANNELS; i++) begin
                        count_s[i]  = {WIDTH{1'b0}};
                        shadow_s[i] = period[i*WIDTH +: WIDTH];
                    end
                end else if (wrap0_s && !cfg[1]) begin
                    state_s = DONE;
                    for (int i = 0; i < N_CHANNELS; i++) begin
                        count_s[i] = {WIDTH{1'b0}};
                    end
                end else begin
                    tvalid_s  = 1'b1;
                    restart_s = wrap0_s;
                    // Shadows only follow period at a pass boundary so a live pass keeps its length.
                    for (int i = 0; i < N_CHANNELS; i++) begin
                        if (count_r[i] == shadow_r[i]) begin
                            count_s[i]  = {WIDTH{1'b0}};
                            shadow_s[i] = period[i*WIDTH +: WIDTH];
                        end else begin
                            count_s[i]  = count_r[i] + {{(WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
            end
            DONE: begin
                for (int i = 0; i < N_CHANNELS; i++) begin
                    count_s[i] = {WIDTH{1'b0}};
                end
                if (!cfg[0]) begin
                    state_s = IDLE;
                end else if (sw_rise_s) begin
                    state_s   = RUN;
                    restart_s = 1'b1;
                    tvalid_s  = 1'b1;
                    for (int i = 0; i < N_CHANNELS; i++) begin
                        shadow_s[i] = period[i*WIDTH +: WIDTH];
                    end
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                for (int i = 0; i < N_CHANNELS; i++) begin
                    count_s[i] = {WIDTH{1'b0}};
                end
            end
        endcase
    end

    // State, counters, shadows, restart-edge history and output flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cfg2_r    <= 1'b0;
            restart_r <= 1'b0;
            tvalid_r  <= 1'b0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                count_r[i]  <= {WIDTH{1'b0}};
                shadow_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_r   <= state_s;
            cfg2_r    <= cfg[2];
            restart_r <= restart_s;
            tvalid_r  <= tvalid_s;
            for (int i = 0; i < N_CHANNELS; i++) begin
                count_r[i]  <= count_s[i];
                shadow_r[i] <= shadow_s[i];
            end
        end
    end

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_addr
        assign addr[g*(WIDTH+2) +: (WIDTH+2)] = {count_r[g], 2'b00};
    end

`ifdef ADDRESS_GENERATOR_LATENCY_EN
    logic [1:0] restart_pipe_r;
    logic [1:0] tvalid_pipe_r;

    // Two-stage delay that lines the flags up with BRAM read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            restart_pipe_r <= 2'b00;
            tvalid_pipe_r  <= 2'b00;
        end else begin
            restart_pipe_r <= {restart_pipe_r[0], restart_r};
            tvalid_pipe_r  <= {tvalid_pipe_r[0], tvalid_r};
        end
    end

    assign restart = restart_pipe_r[1];
    assign tvalid  = tvalid_pipe_r[1];
`else
    assign restart = restart_r;
    assign tvalid  = tvalid_r;
`endif

endmodule
